// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and size helper for the data memory unit
package dmem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;
   typedef enum logic {IDLE, BEAT2} state_t;
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      return sz == SZ_BYTE ? 3'd1 : sz == SZ_HALF ? 3'd2 : 3'd4;
   endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word-wide single-port RAM with byte enables and registered read
module dmem_ram #(
   parameter int DEPTH_BYTES  = 1024,
   parameter int INIT_PATTERN = 1,
   localparam int IW = $clog2(DEPTH_BYTES / 4)
) (
   input  logic          clk,
   input  logic [IW-1:0] i_addr,
   input  logic [3:0]    i_be,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);
   logic [31:0] r_mem [DEPTH_BYTES / 4];
   logic [31:0] r_rdata;
   logic [31:0] w_init;
   // Storage powers up cleared and holds data XOR the init pattern, so a cleared array reads as the pattern
   assign w_init  = INIT_PATTERN != 0 ? {24'b0, 8'({i_addr, 2'b00}) + 8'd4} : '0;
   assign o_rdata = r_rdata;
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8] ^ w_init[8*b +: 8];
      r_rdata <= r_mem[i_addr] ^ w_init;
   end
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: big-endian byte-addressed data memory with sized, sign-extending and
// word-crossing accesses, range checking, valid/ready requests and a one-cycle response
module data_mem_unit
   import dmem_pkg::*;
#(
   parameter int DEPTH_BYTES  = 1024,
   parameter int ADDR_W       = 32,
   parameter int INIT_PATTERN = 1,
   localparam int IW = $clog2(DEPTH_BYTES / 4)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);
   state_t          r_state, w_next;
   logic            r_rsp_valid, r_we, r_err, r_signed, r_cross;
   logic [1:0]      r_off;
   logic [2:0]      r_n;
   logic [IW-1:0]   r_idx2;
   logic [31:0]     r_wd2, r_hi;
   logic [3:0]      r_be2;
   logic            w_acc, w_err, w_cross, w_split;
   logic [1:0]      w_off;
   logic [2:0]      w_n;
   logic [IW-1:0]   w_idx, w_ram_addr;
   logic [ADDR_W:0] w_end;
   logic [31:0]     w_ljust, w_ram_wd, w_ram_rdata, w_lj, w_val, w_ext;
   logic [63:0]     w_wide, w_dw;
   logic [3:0]      w_be_l, w_ram_be;
   logic [7:0]      w_be;
   logic [5:0]      w_base;
   assign req_ready = r_state == IDLE;
   assign w_acc     = req_valid && req_ready;
   assign w_n       = size_bytes(req_size);
   assign w_off     = req_addr[1:0];
   assign w_idx     = req_addr[IW+1:2];
   // One extra address bit so an access running past the top of the address space is not wrapped
   assign w_end     = {1'b0, req_addr} + (ADDR_W+1)'(w_n);
   assign w_err     = req_size == SZ_RSVD || w_end > (ADDR_W+1)'(DEPTH_BYTES);
   assign w_cross   = ({1'b0, w_off} + w_n) > 3'd4;
   assign w_split   = w_cross && !w_err;
   // Place the store bytes in an 8-byte window: upper half is beat 1, lower half is beat 2
   assign w_ljust   = req_wdata << {3'd4 - w_n, 3'b000};
   assign w_wide    = {w_ljust, 32'b0} >> {w_off, 3'b000};
   assign w_be_l    = 4'hF << (3'd4 - w_n);
   assign w_be      = {w_be_l, 4'b0000} >> w_off;
   assign w_ram_addr = r_state == BEAT2 ? r_idx2 : w_idx;
   assign w_ram_wd   = r_state == BEAT2 ? r_wd2 : w_wide[63:32];
   assign w_ram_be   = r_state == BEAT2 ? (r_we ? r_be2 : 4'b0) :
                       (w_acc && req_we && !w_err) ? w_be[7:4] : 4'b0;
   dmem_ram #(.DEPTH_BYTES(DEPTH_BYTES), .INIT_PATTERN(INIT_PATTERN)) u_ram (
      .clk     (clk),
      .i_addr  (w_ram_addr),
      .i_be    (w_ram_be),
      .i_wdata (w_ram_wd),
      .o_rdata (w_ram_rdata)
   );
   assign w_dw   = r_cross ? {r_hi, w_ram_rdata} : {w_ram_rdata, 32'b0};
   assign w_base = 6'd32 - {1'b0, r_off, 3'b000};
   assign w_lj   = w_dw[w_base +: 32];
   assign w_val  = w_lj >> {3'd4 - r_n, 3'b000};
   assign w_ext  = r_n == 3'd1 ? {{24{r_signed & w_val[7]}}, w_val[7:0]} :
                   r_n == 3'd2 ? {{16{r_signed & w_val[15]}}, w_val[15:0]} : w_val;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_valid && r_err;
   assign rsp_rdata = (r_rsp_valid && !r_we && !r_err) ? w_ext : 32'b0;
   always_comb begin
      w_next = IDLE;
      if (r_state == IDLE && w_acc && w_split) w_next = BEAT2;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_we        <= 1'b0;
         r_err       <= 1'b0;
         r_signed    <= 1'b0;
         r_cross     <= 1'b0;
         r_off       <= '0;
         r_n         <= '0;
         r_idx2      <= '0;
         r_wd2       <= '0;
         r_be2       <= '0;
         r_hi        <= '0;
      end else begin
         r_rsp_valid <= r_state == BEAT2 || (w_acc && !w_split);
         if (w_acc) begin
            r_we     <= req_we;
            r_err    <= w_err;
            r_signed <= req_signed;
            r_cross  <= w_split;
            r_off    <= w_off;
            r_n      <= w_n;
            r_idx2   <= w_idx + IW'(1);
            r_wd2    <= w_wide[31:0];
            r_be2    <= w_be[3:0];
         end
         if (r_state == BEAT2) r_hi <= w_ram_rdata;
      end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: scoreboard bench with a byte-array reference model of the data memory
module tb_data_mem_unit;
   import dmem_pkg::*;
   localparam int DEPTH = 1024;
   typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
   logic        clk, rst_n, req_valid, req_ready, req_we, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, rsp_rdata;
   logic        rsp_valid, rsp_err;
   logic [7:0]  mem [DEPTH];
   exp_t        sb[$];
   exp_t        m_e;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   data_mem_unit #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .INIT_PATTERN(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // Drive one request at the current negedge; the model decides its outcome at acceptance
   task automatic req(input logic we, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wd, input bit cut = 0);
      int n, b;
      longint unsigned a;
      logic [31:0] v;
      bit err;
      exp_t e;
      req_valid = 0;
      b = 0;
      while (!req_ready && b < 16) begin @(negedge clk); b++; end
      if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1; req_we = we; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wd;
      n = sz == SZ_BYTE ? 1 : sz == SZ_HALF ? 2 : sz == SZ_WORD ? 4 : 0;
      a = addr;
      err = sz == SZ_RSVD || a + longint'(n) > DEPTH;
      v = 0;
      if (!err)
         for (int j = 0; j < n; j++) begin
            if (cut && j > 0 && (a + j) % 4 == 0) break;
            if (we) mem[a + j] = 8'(wd >> (8 * (n - 1 - j)));
            else v = (v << 8) | 32'(mem[a + j]);
         end
      if (!we && sgn && n < 4 && v[8*n-1]) v = v | (~32'h0 << (8 * n));
      e.rdata = (we || err) ? 32'h0 : v;
      e.err   = err;
      e.cyc   = cyc + ((!err && (a % 4) + n > 4) ? 2 : 1);
      if (!cut) sb.push_back(e);
      @(negedge clk);
   endtask
   always @(negedge clk)
      if (rsp_valid) begin
         if (sb.size() == 0) chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
         else begin
            m_e = sb.pop_front();
            chk("rsp_cycle", 32'(cyc), 32'(m_e.cyc));
            chk("rsp_rdata", rsp_rdata, m_e.rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_e.err});
         end
      end
   initial begin
      int b;
      logic [31:0] ra;
      for (int k = 0; k < DEPTH; k++) mem[k] = ((k + 1) % 4 == 0) ? 8'(k + 1) : 8'h00;
      rst_n = 0; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      rst_n = 1;
      @(negedge clk);
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      req(0, SZ_WORD, 0, 32'h0, 0);
      req(1, SZ_WORD, 0, 32'h10, 32'hA1B2C3D4);
      req(0, SZ_BYTE, 1, 32'h11, 0);
      req(0, SZ_BYTE, 0, 32'h11, 0);
      req(1, SZ_HALF, 0, 32'h23, 32'h8001);
      chk("ready_low_beat2", {31'b0, req_ready}, 32'd0);
      req_valid = 0;
      @(negedge clk);
      chk("ready_after_beat2", {31'b0, req_ready}, 32'd1);
      req(0, SZ_HALF, 1, 32'h23, 0);
      req(0, SZ_WORD, 0, 32'h20, 0);
      req(0, SZ_WORD, 0, DEPTH - 2, 0);
      chk("err_no_beat2", {31'b0, req_ready}, 32'd1);
      req(0, SZ_RSVD, 0, 32'h0, 0);
      req(1, SZ_WORD, 0, DEPTH - 1, 32'hDEADBEEF);
      req(0, SZ_BYTE, 0, 32'hFFFFFFFF, 0);
      req(0, SZ_WORD, 0, DEPTH - 4, 0);
      req(0, SZ_BYTE, 0, DEPTH - 1, 0);
      req(1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D);
      req(0, SZ_WORD, 0, 32'h40, 0);
      req(1, SZ_WORD, 0, 32'h62, 32'h11223344, 1);
      rst_n = 0;
      req_valid = 0;
      repeat (2) @(negedge clk);
      chk("rst_beat2_rsp", {31'b0, rsp_valid}, 32'd0);
      rst_n = 1;
      @(negedge clk);
      chk("rst_beat2_ready", {31'b0, req_ready}, 32'd1);
      req(0, SZ_WORD, 0, 32'h60, 0);
      req(0, SZ_WORD, 0, 32'h64, 0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin req_valid = 0; @(negedge clk); end
         b  = $urandom_range(0, 19);
         ra = b == 0 ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) :
              b == 1 ? 32'(DEPTH - $urandom_range(1, 4)) : 32'($urandom_range(0, DEPTH - 1));
         req(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0 ? SZ_RSVD : 2'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), ra, $urandom);
      end
      req_valid = 0;
      b = 0;
      while (sb.size() != 0 && b < 20) begin @(negedge clk); b++; end
      if (sb.size() != 0) chk("lost_rsp", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
